// File: rtl/forward_ctrl_pkg.sv
// rtl/forward_ctrl_pkg.sv - shared forwarding select encodings and register-index width
package forward_ctrl_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;

  typedef logic [1:0] fwd_sel_t;

  // Operand mux selects shared with the EX-stage datapath; 2'b11 is unused.
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/forward_ctrl_if.sv
// rtl/forward_ctrl_if.sv - ID-stage tag, flush and hazard/forward result bundle
interface forward_ctrl_if #(
  parameter int REG_ADDR_W = forward_ctrl_pkg::DEFAULT_REG_ADDR_W
);
  import forward_ctrl_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic                  stall;
  fwd_sel_t              fwd_a_sel;
  fwd_sel_t              fwd_b_sel;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel
  );

endinterface

// File: rtl/forward_ctrl_fwd_select.sv
// rtl/forward_ctrl_fwd_select.sv - per-operand forward source priority compare
module fwd_select
  import forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  wb_valid_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  output fwd_sel_t              sel_o
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired zero, so it is never a producer.
  assign mem_hit = mem_valid_i & mem_reg_write_i & (mem_rd_i != '0) & (mem_rd_i == ex_rs_i);
  assign wb_hit  = wb_valid_i  & wb_reg_write_i  & (wb_rd_i  != '0) & (wb_rd_i  == ex_rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (ex_valid_i) begin
      if (mem_hit) begin
        sel_o = FWD_MEM;
      end else if (wb_hit) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// rtl/forward_ctrl.sv - EX/MEM/WB tag pipeline with load-use stall and operand forwarding
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic          clk,
  input  logic          arst,
  forward_ctrl_if.slave bus
);

  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic                  mem_mem_read_q, mem_mem_read_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic                  load_use;
  logic                  ex_bubble;

  assign load_use = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & bus.id_valid &
                    ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
  assign bus.stall = load_use & ~bus.flush;

  always_comb begin
    ex_bubble       = bus.flush | bus.stall | ~bus.id_valid;
    ex_valid_d      = ~ex_bubble;
    ex_rs1_d        = ex_bubble ? '0 : bus.id_rs1;
    ex_rs2_d        = ex_bubble ? '0 : bus.id_rs2;
    ex_rd_d         = ex_bubble ? '0 : bus.id_rd;
    ex_reg_write_d  = ~ex_bubble & bus.id_reg_write;
    ex_mem_read_d   = ~ex_bubble & bus.id_mem_read;
    // A flush kills the EX instruction on its way to MEM; WB still drains.
    mem_valid_d     = ex_valid_q & ~bus.flush;
    mem_rd_d        = bus.flush ? '0 : ex_rd_q;
    mem_reg_write_d = ex_reg_write_q & ~bus.flush;
    mem_mem_read_d  = ex_mem_read_q & ~bus.flush;
    wb_valid_d      = mem_valid_q;
    wb_rd_d         = mem_rd_q;
    wb_reg_write_d  = mem_reg_write_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_valid_q      <= 1'b0;
      ex_rs1_q        <= '0;
      ex_rs2_q        <= '0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rs1_q        <= ex_rs1_d;
      ex_rs2_q        <= ex_rs2_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_mem_read_q  <= mem_mem_read_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
    end
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_valid_i      (ex_valid_q),
    .ex_rs_i         (ex_rs1_q),
    .mem_valid_i     (mem_valid_q),
    .mem_reg_write_i (mem_reg_write_q),
    .mem_rd_i        (mem_rd_q),
    .wb_valid_i      (wb_valid_q),
    .wb_reg_write_i  (wb_reg_write_q),
    .wb_rd_i         (wb_rd_q),
    .sel_o           (bus.fwd_a_sel)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_valid_i      (ex_valid_q),
    .ex_rs_i         (ex_rs2_q),
    .mem_valid_i     (mem_valid_q),
    .mem_reg_write_i (mem_reg_write_q),
    .mem_rd_i        (mem_rd_q),
    .wb_valid_i      (wb_valid_q),
    .wb_reg_write_i  (wb_reg_write_q),
    .wb_rd_i         (wb_rd_q),
    .sel_o           (bus.fwd_b_sel)
  );

  // Load data is not available in MEM, so a load there must never be forwarded;
  // the one-cycle stall guarantees its consumer sees it only from WB.
  a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (arst)
    !(mem_valid_q && mem_mem_read_q &&
      (bus.fwd_a_sel == FWD_MEM || bus.fwd_b_sel == FWD_MEM)));

  a_stall_one_cycle: assert property (@(posedge clk) disable iff (arst)
    bus.stall |=> !bus.stall);

endmodule
